matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameters SHALL be:
- NUM_ROWS, default 9: number of 64-bit words fetched. Word 0 is vector B; words 1..8 are matrix A rows.
- BASE_ADDR, default 32'h0: word address of word 0.
- DATA_WIDTH, default 8: FIFO byte width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock; all logic is rising-edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a load.
- busy, out, 1: load in progress.
- done, out, 1: load complete; held until the next accepted start.
- avm_address, out, 32: word address of the read master.
- avm_read, out, 1: read request.
- avm_readdata, in, 64: returned word.
- avm_readdatavalid, in, 1: avm_readdata is valid this cycle.
- avm_waitrequest, in, 1: slave stall.
- fifo_wrreq, out, NUM_ROWS: one-hot write strobe; bit n drives FIFO n.
- fifo_data, out, DATA_WIDTH: byte shared by all FIFOs.
- fifo_full, in, NUM_ROWS: wrfull flag of each FIFO.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, WAIT, UNPACK and DONE, with a row counter (0..NUM_ROWS-1) and a byte counter (0..7).
REQ-004 IDLE/DONE with start=1: clear row to 0 and byte to 0, clear done, go to REQ. start in REQ/WAIT/UNPACK SHALL be ignored.
REQ-005 In REQ:
- avm_read SHALL be 1 and avm_address SHALL be BASE_ADDR+row, both registered.
- Both SHALL be held stable while avm_waitrequest=1.
- The read is accepted on the first cycle with avm_read=1 and avm_waitrequest=0.
- On acceptance, the next state is WAIT and avm_read drops to 0 on that edge.
REQ-006 At most one read SHALL be outstanding; avm_read SHALL be 0 in every state except REQ.
REQ-007 In WAIT, avm_readdatavalid=1 SHALL capture avm_readdata into a 64-bit holding register, clear byte to 0 and go to UNPACK. There is no timeout; WAIT holds indefinitely.
REQ-008 avm_readdatavalid outside WAIT SHALL be ignored and SHALL NOT alter the holding register.
REQ-009 In UNPACK:
- fifo_data SHALL equal hold[8*byte+7 : 8*byte], least-significant byte first.
- fifo_wrreq[row] SHALL equal ~fifo_full[row] (combinational); all other bits SHALL be 0.
- byte SHALL increment only on cycles where the write is issued.
REQ-010 fifo_full[row]=1 SHALL stall UNPACK with no write and no counter change. Data SHALL NOT be dropped or duplicated.
REQ-011 After the write of byte 7:
- If row<NUM_ROWS-1: row increments and the FSM goes to REQ.
- If row=NUM_ROWS-1: the FSM goes to DONE.
REQ-012 fifo_wrreq SHALL be all-zero in every state except UNPACK. fifo_full bits other than fifo_full[row] SHALL be ignored.
REQ-013 busy SHALL be 1 exactly in REQ, WAIT and UNPACK. done SHALL be 1 exactly in DONE.
REQ-014 Timing with no stalls (waitrequest=0, readdatavalid one cycle after acceptance, no full):
- start sampled at edge T; avm_read is high in cycle T+1.
- The first fifo_wrreq is in cycle T+3.
- Each row takes 10 cycles.
- done rises 10*NUM_ROWS cycles after T (90 for the default).
REQ-015 Address arithmetic SHALL be 32-bit and wrap modulo 2^32.

Reset
REQ-016 rst_n=0 at any time, including mid-read or mid-UNPACK, SHALL immediately force:
- state IDLE;
- busy=0, done=0, avm_read=0, avm_address=BASE_ADDR;
- fifo_wrreq=0, fifo_data=0;
- row=0, byte=0, holding register=0.
REQ-017 A readdatavalid pending from a read interrupted by reset SHALL be ignored per REQ-008.

Verification
REQ-018 Nominal: zero-wait memory with word n = {8{8'(n+1)}}, start pulse. Required:
- FIFO n receives eight bytes of value n+1.
- Exactly 72 writes in total.
- done at T+90, busy low.
REQ-019 waitrequest=1 for 5 cycles on the row-3 request. Required:
- avm_address=BASE_ADDR+3 and avm_read=1 are stable across all 5 cycles.
- Exactly one read is accepted.
- done is delayed by 5 cycles.
REQ-020 Word 0 = 64'h0807060504030201, fifo_full[0] forced high for 4 cycles after byte 2. Required:
- FIFO 0 receives 01..08 in order with no duplicates.
- No fifo_wrreq while full.
REQ-021 Spurious avm_readdatavalid in IDLE and in REQ. Required: holding register unchanged and no FIFO writes.
REQ-022 rst_n asserted in UNPACK of row 4, byte 5. Required:
- All outputs go to reset values immediately.
- A subsequent start reloads from row 0 and address BASE_ADDR.
REQ-023 start pulsed in UNPACK and again in DONE. Required:
- The first pulse is ignored.
- The second pulse clears done and restarts the load at row 0.

Source files
------------

// File: rtl/matrix_loader.sv
// Fetches NUM_ROWS 64-bit words over an Avalon-MM read master and unpacks each
// word, least-significant byte first, into the FIFO selected by its row index.
module matrix_loader #(
  parameter int          NUM_ROWS   = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           avm_address,
  output logic                  avm_read,
  input  logic [63:0]           avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest,
  output logic [NUM_ROWS-1:0]   fifo_wrreq,
  output logic [DATA_WIDTH-1:0] fifo_data,
  input  logic [NUM_ROWS-1:0]   fifo_full
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_UNPACK,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ROW_W-1:0]  r_row;
  logic [ROW_W-1:0]  w_row_next;
  logic [2:0]        r_byte;
  logic [2:0]        w_byte_next;
  logic [63:0]       r_hold;
  logic              r_avm_read;
  logic              w_avm_read_next;
  logic [31:0]       r_avm_address;
  logic [31:0]       w_avm_address_next;
  logic              w_write;
  logic [7:0]        w_byte_val;

  assign w_write    = (r_state == S_UNPACK) && !fifo_full[r_row];
  assign w_byte_val = r_hold[{r_byte, 3'b000} +: 8];

  always_comb begin
    w_state_next       = r_state;
    w_row_next         = r_row;
    w_byte_next        = r_byte;
    w_avm_read_next    = r_avm_read;
    w_avm_address_next = r_avm_address;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next       = S_REQ;
          w_row_next         = '0;
          w_byte_next        = '0;
          w_avm_read_next    = 1'b1;
          w_avm_address_next = BASE_ADDR;
        end
      end
      S_REQ: begin
        if (!avm_waitrequest) begin
          w_state_next    = S_WAIT;
          w_avm_read_next = 1'b0;
        end
      end
      S_WAIT: begin
        if (avm_readdatavalid) begin
          w_state_next = S_UNPACK;
          w_byte_next  = '0;
        end
      end
      S_UNPACK: begin
        // Counters only advance on cycles where the byte actually went out
        if (w_write) begin
          w_byte_next = r_byte + 3'd1;
          if (r_byte == 3'd7) begin
            if (r_row == LAST_ROW) begin
              w_state_next = S_DONE;
            end else begin
              w_state_next       = S_REQ;
              w_row_next         = r_row + ROW_W'(1);
              w_avm_read_next    = 1'b1;
              w_avm_address_next = BASE_ADDR + 32'(r_row) + 32'd1;
            end
          end
        end
      end
      default: begin
        w_state_next    = S_IDLE;
        w_avm_read_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_row         <= '0;
      r_byte        <= '0;
      r_avm_read    <= 1'b0;
      r_avm_address <= BASE_ADDR;
    end else begin
      r_state       <= w_state_next;
      r_row         <= w_row_next;
      r_byte        <= w_byte_next;
      r_avm_read    <= w_avm_read_next;
      r_avm_address <= w_avm_address_next;
    end
  end

  // Only a response to our own outstanding read may load the holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (r_state == S_WAIT && avm_readdatavalid) begin
      r_hold <= avm_readdata;
    end
  end

  always_comb begin
    fifo_wrreq = '0;
    if (w_write) begin
      fifo_wrreq[r_row] = 1'b1;
    end
  end

  assign fifo_data   = (r_state == S_UNPACK) ? DATA_WIDTH'(w_byte_val) : '0;
  assign avm_read    = r_avm_read;
  assign avm_address = r_avm_address;
  assign busy        = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_UNPACK);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: a memory/FIFO environment plus a word-to-byte-queue
// reference model, driven through directed scenarios and randomized loads.
module tb_matrix_loader;

  localparam int          NUM_ROWS = 9;
  localparam logic [31:0] BASE     = 32'hFFFF_FFFC;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic                busy;
  logic                done;
  logic [31:0]         avm_address;
  logic                avm_read;
  logic [63:0]         avm_readdata;
  logic                avm_readdatavalid;
  logic                avm_waitrequest;
  logic [NUM_ROWS-1:0] fifo_wrreq;
  logic [7:0]          fifo_data;
  logic [NUM_ROWS-1:0] fifo_full;

  matrix_loader #(
    .NUM_ROWS  (NUM_ROWS),
    .BASE_ADDR (BASE),
    .DATA_WIDTH(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest),
    .fifo_wrreq       (fifo_wrreq),
    .fifo_data        (fifo_data),
    .fifo_full        (fifo_full)
  );

  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          t0 = 0;
  int          totalWrites = 0;
  int          firstWriteCycle = -1;
  int          stallCycles = 0;
  logic [63:0] mem [NUM_ROWS];
  logic [7:0]  fifoQ [NUM_ROWS][$];
  logic [31:0] acceptedAddrQ [$];

  logic        acceptPending = 1'b0;
  logic [31:0] acceptAddr = '0;
  logic        prevStall = 1'b0;
  logic [31:0] prevAddr = '0;
  logic        spuriousOn = 1'b0;
  logic        stallArm = 1'b0;
  int          stallRow = 0;
  int          stallUsed = 0;
  logic        fullArm = 1'b0;
  logic        fullFired = 1'b0;
  int          fullLeft = 0;
  logic        randWait = 1'b0;
  logic        randFull = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [63:0] memWord(input logic [31:0] addr);
    logic [31:0] idx;
    idx = addr - BASE;
    if (idx < 32'(NUM_ROWS)) return mem[int'(idx)];
    return 64'hBAD0_BAD0_BAD0_BAD0;
  endfunction

  // Memory slave and FIFO-full generator, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (!stallArm) stallUsed = 0;
    if (stallArm && stallUsed < 5 && avm_read && avm_address == BASE + 32'(stallRow)) begin
      avm_waitrequest = 1'b1;
      stallUsed++;
    end else if (randWait) begin
      avm_waitrequest = ($urandom_range(0, 3) == 0);
    end else begin
      avm_waitrequest = 1'b0;
    end
    if (!fullArm) begin
      fullFired = 1'b0;
    end else if (!fullFired && fifoQ[0].size() == 3) begin
      fullFired = 1'b1;
      fullLeft  = 4;
    end
    fifo_full = '0;
    if (randFull) begin
      for (int n = 0; n < NUM_ROWS; n++) fifo_full[n] = ($urandom_range(0, 3) == 0);
    end
    if (fullLeft > 0) begin
      fifo_full[0] = 1'b1;
      fullLeft--;
    end
    avm_readdatavalid = acceptPending || spuriousOn;
    avm_readdata      = acceptPending ? memWord(acceptAddr) : 64'hDEAD_BEEF_BAAD_F00D;
  end

  // Bus/FIFO monitor feeding the scoreboard queues
  always @(negedge clk) begin
    if (!rst_n) begin
      acceptPending = 1'b0;
      prevStall     = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("avm_read_held", 64'(avm_read), 64'd1);
        checkOutput("avm_addr_held", 64'(avm_address), 64'(prevAddr));
      end
      prevStall = avm_read && avm_waitrequest;
      prevAddr  = avm_address;
      if (avm_read && avm_waitrequest) stallCycles++;
      acceptPending = avm_read && !avm_waitrequest;
      if (acceptPending) begin
        acceptAddr = avm_address;
        acceptedAddrQ.push_back(avm_address);
      end
      if (fifo_wrreq != '0) begin
        checkOutput("wrreq_onehot", 64'($onehot(fifo_wrreq)), 64'd1);
        checkOutput("wrreq_while_full", 64'(fifo_wrreq & fifo_full), 64'd0);
        for (int n = 0; n < NUM_ROWS; n++) begin
          if (fifo_wrreq[n]) begin
            if (totalWrites == 0) firstWriteCycle = cycleCount;
            fifoQ[n].push_back(fifo_data);
            totalWrites++;
          end
        end
      end
    end
  end

  task automatic clearModel();
    for (int n = 0; n < NUM_ROWS; n++) fifoQ[n].delete();
    acceptedAddrQ.delete();
    totalWrites     = 0;
    firstWriteCycle = -1;
    stallCycles     = 0;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cycleCount;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_done"}, 64'(done), 64'd0);
    checkOutput({tag, "_avm_read"}, 64'(avm_read), 64'd0);
    checkOutput({tag, "_avm_addr"}, 64'(avm_address), 64'(BASE));
    checkOutput({tag, "_wrreq"}, 64'(fifo_wrreq), 64'd0);
    checkOutput({tag, "_fifo_data"}, 64'(fifo_data), 64'd0);
  endtask

  // Expected: each FIFO n holds the bytes of word n LSB first, one read per row
  task automatic verifyLoad(input int expCycles, input string tag);
    int          waited;
    logic [63:0] assembled;
    logic [31:0] expAddr;
    waited = 0;
    while (done !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_busy_low"}, 64'(busy), 64'd0);
    if (expCycles >= 0) checkOutput({tag, "_cycles"}, 64'(cycleCount - t0), 64'(expCycles));
    checkOutput({tag, "_total_writes"}, 64'(totalWrites), 64'(8 * NUM_ROWS));
    checkOutput({tag, "_reads"}, 64'(acceptedAddrQ.size()), 64'(NUM_ROWS));
    for (int i = 0; i < acceptedAddrQ.size() && i < NUM_ROWS; i++) begin
      expAddr = BASE + 32'(i);
      checkOutput($sformatf("%s_addr%0d", tag, i), 64'(acceptedAddrQ[i]), 64'(expAddr));
    end
    for (int n = 0; n < NUM_ROWS; n++) begin
      checkOutput($sformatf("%s_fifo%0d_count", tag, n), 64'(fifoQ[n].size()), 64'd8);
      assembled = '0;
      for (int b = 0; b < fifoQ[n].size() && b < 8; b++) assembled[8*b +: 8] = fifoQ[n][b];
      checkOutput($sformatf("%s_fifo%0d_bytes", tag, n), assembled, mem[n]);
    end
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    start = 1'b0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    fifo_full         = '0;
    for (int n = 0; n < NUM_ROWS; n++) mem[n] = {8{8'(n + 1)}};

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkResetOutputs("idle");

    $display("[TB] spurious readdatavalid in IDLE");
    clearModel();
    spuriousOn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_spur_wrreq", 64'(fifo_wrreq), 64'd0);
      checkOutput("idle_spur_busy", 64'(busy), 64'd0);
    end
    spuriousOn = 1'b0;
    @(negedge clk);
    checkOutput("idle_spur_writes", 64'(totalWrites), 64'd0);

    $display("[TB] nominal load");
    clearModel();
    applyStimulus();
    checkOutput("nom_first_read", 64'(avm_read), 64'd1);
    checkOutput("nom_first_addr", 64'(avm_address), 64'(BASE));
    verifyLoad(10 * NUM_ROWS, "nom");
    checkOutput("nom_first_write_cycle", 64'(firstWriteCycle - t0), 64'd2);

    $display("[TB] waitrequest on row 3");
    clearModel();
    stallRow = 3;
    stallArm = 1'b1;
    applyStimulus();
    verifyLoad(10 * NUM_ROWS + 5, "stall3");
    checkOutput("stall3_stall_cycles", 64'(stallCycles), 64'd5);
    stallArm = 1'b0;

    $display("[TB] fifo_full on FIFO 0");
    clearModel();
    mem[0]  = 64'h0807060504030201;
    fullArm = 1'b1;
    applyStimulus();
    verifyLoad(10 * NUM_ROWS + 4, "full0");
    fullArm = 1'b0;

    $display("[TB] spurious readdatavalid in REQ");
    clearModel();
    stallRow = 0;
    stallArm = 1'b1;
    applyStimulus();
    spuriousOn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("req_spur_read", 64'(avm_read), 64'd1);
      checkOutput("req_spur_wrreq", 64'(fifo_wrreq), 64'd0);
    end
    spuriousOn = 1'b0;
    verifyLoad(10 * NUM_ROWS + 5, "req_spur");
    stallArm = 1'b0;

    $display("[TB] start in UNPACK ignored, restart from DONE");
    clearModel();
    applyStimulus();
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(negedge clk);
      if (fifo_wrreq[2]) found = 1'b1;
    end
    checkOutput("unpack_row2_reached", 64'(found), 64'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    verifyLoad(10 * NUM_ROWS, "ign_start");
    clearModel();
    applyStimulus();
    checkOutput("restart_done_cleared", 64'(done), 64'd0);
    checkOutput("restart_busy", 64'(busy), 64'd1);
    checkOutput("restart_read", 64'(avm_read), 64'd1);
    checkOutput("restart_addr", 64'(avm_address), 64'(BASE));
    verifyLoad(10 * NUM_ROWS, "restart");

    $display("[TB] reset in UNPACK row 4 byte 5");
    clearModel();
    applyStimulus();
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      @(posedge clk);
      #3;
      if (fifo_wrreq[4] && fifoQ[4].size() == 5) found = 1'b1;
    end
    checkOutput("row4_byte5_reached", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(negedge clk);
    checkResetOutputs("midrst_hold");
    rst_n = 1'b1;
    clearModel();
    applyStimulus();
    checkOutput("postrst_addr", 64'(avm_address), 64'(BASE));
    verifyLoad(10 * NUM_ROWS, "postrst");

    $display("[TB] randomized loads");
    randWait = 1'b1;
    randFull = 1'b1;
    for (int it = 0; it < 3; it++) begin
      for (int n = 0; n < NUM_ROWS; n++) mem[n] = {$urandom, $urandom};
      clearModel();
      applyStimulus();
      verifyLoad(-1, $sformatf("rand%0d", it));
    end
    randWait = 1'b0;
    randFull = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
